phase_cmd_arbiter: RTL

- Shares the single 24-bit command/reply port of the phase generator between N_REQ on-chip requesters, e.g. the host UART bridge and a pattern sequencer.
- Enforces the phase block's timing rules: no commands during its startup window, and an idle gap after every command so the write-address auto-increment fires.
- Supports locked bursts, such as an 'a' followed by several 'w', and routes each reply back to the requester that issued the command.
- Sits between the requesters and the phase block, entirely in the command clock domain.

---
 rtl/phase_cmd_pkg.sv | 33 +++
 rtl/phase_cmd_arbiter_rr_pick.sv | 31 +++
 rtl/phase_cmd_arbiter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/phase_cmd_pkg.sv
// Shared definitions for the phase-generator command path: word layout,
// ASCII opcodes, reply error bits and the arbiter state encoding.
package phase_cmd_pkg;

   localparam int CMD_W = 24;

   localparam logic [7:0] OP_A = "a";
   localparam logic [7:0] OP_W = "w";
   localparam logic [7:0] OP_B = "b";
   localparam logic [7:0] OP_N = "n";
   localparam logic [7:0] OP_C = "c";
   localparam logic [7:0] OP_G = "g";
   localparam logic [7:0] OP_S = "s";

   localparam int ERR_INVALID_CMD  = 0;
   localparam int ERR_INVALID_DATA = 1;
   localparam int ERR_OVERFLOW     = 7;

   // Opcode ASCII case bit inside the command word; uppercase requests a reply.
   localparam int CAPS_BIT = 21;

   typedef enum logic [1:0] {
      ST_STARTUP,
      ST_IDLE,
      ST_ISSUE,
      ST_GAP
   } arb_state_e;

   function automatic logic [CMD_W-1:0] make_cmd(input logic [7:0] op, input logic [15:0] arg);
      return {op, arg};
   endfunction

endpackage

// File: rtl/phase_cmd_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester with req & mask set,
// searching upward from ptr_i+1 and wrapping.
module rr_pick #(
   parameter int N  = 2,
   parameter int PW = $clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [N-1:0]  mask_i,
   input  logic [PW-1:0] ptr_i,
   output logic [N-1:0]  grant_o,
   output logic [PW-1:0] grant_idx_o,
   output logic          any_o
);
   import phase_cmd_pkg::*;

   always_comb begin
      grant_o     = '0;
      grant_idx_o = '0;
      any_o       = 1'b0;
      for (int ofs = 1; ofs <= N; ofs++) begin
         for (int j = 0; j < N; j++) begin
            if (!any_o && (j == (int'(ptr_i) + ofs) % N) && req_i[j] && mask_i[j]) begin
               any_o       = 1'b1;
               grant_o[j]  = 1'b1;
               grant_idx_o = PW'(j);
            end
         end
      end
   end

endmodule

// File: rtl/phase_cmd_arbiter.sv
// Arbiter in front of the phase generator command port: startup hold-off,
// forced idle gap after each command, locked bursts and reply routing.
module phase_cmd_arbiter #(
   parameter int N_REQ          = 2,
   parameter int STARTUP_CYCLES = 520,
   parameter int GAP_CYCLES     = 1,
   parameter int LOCK_TIMEOUT   = 16,
   parameter int CMD_W          = 24
) (
   input  logic                   i_command_clk,
   input  logic                   i_reset,
   input  logic [N_REQ-1:0]       i_req_valid,
   input  logic [N_REQ-1:0]       i_req_lock,
   input  logic [N_REQ*CMD_W-1:0] i_req_data,
   output logic [N_REQ-1:0]       o_req_ready,
   output logic                   o_command,
   output logic [CMD_W-1:0]       o_command_data,
   input  logic                   i_reply,
   input  logic [CMD_W-1:0]       i_reply_data,
   output logic [N_REQ-1:0]       o_reply_valid,
   output logic [CMD_W-1:0]       o_reply_data,
   output logic                   o_busy,
   output logic                   o_orphan
);
   import phase_cmd_pkg::*;

   localparam int PW  = $clog2(N_REQ);
   localparam int SCW = $clog2(STARTUP_CYCLES + 1);
   localparam int GCW = $clog2(GAP_CYCLES + 1);
   localparam int LCW = $clog2(LOCK_TIMEOUT + 1);

   arb_state_e       state_q, state_d;
   logic [SCW-1:0]   start_cnt_q, start_cnt_d;
   logic [GCW-1:0]   gap_cnt_q, gap_cnt_d;
   logic [PW-1:0]    ptr_q, ptr_d;
   logic             lock_q, lock_d;
   logic [PW-1:0]    lock_owner_q, lock_owner_d;
   logic [LCW-1:0]   lock_cnt_q, lock_cnt_d;
   logic [PW-1:0]    tag_q, tag_d;
   logic             window_q, window_d;
   logic             cmd_q, cmd_d;
   logic [CMD_W-1:0] cmd_data_q, cmd_data_d;
   logic [N_REQ-1:0] reply_valid_q, reply_valid_d;
   logic [CMD_W-1:0] reply_data_q, reply_data_d;
   logic             orphan_q, orphan_d;

   logic             lock_active;
   logic             in_idle;
   logic             xfer;
   logic [N_REQ-1:0] pick_mask;
   logic [N_REQ-1:0] pick;
   logic [PW-1:0]    win_idx;
   logic             pick_any;
   logic [CMD_W-1:0] req_word [N_REQ];

   // A lock whose counter has run out no longer restricts the pick.
   assign lock_active = lock_q && (lock_cnt_q != '0);

   genvar gi;
   for (gi = 0; gi < N_REQ; gi++) begin : g_req
      assign req_word[gi]      = i_req_data[gi*CMD_W +: CMD_W];
      assign pick_mask[gi]     = !lock_active || (lock_owner_q == PW'(gi));
      assign reply_valid_d[gi] = i_reply && window_q && (tag_q == PW'(gi));
   end

   rr_pick #(.N(N_REQ), .PW(PW)) u_pick (
      .req_i       (i_req_valid),
      .mask_i      (pick_mask),
      .ptr_i       (ptr_q),
      .grant_o     (pick),
      .grant_idx_o (win_idx),
      .any_o       (pick_any)
   );

   assign in_idle     = (state_q == ST_IDLE);
   assign xfer        = in_idle && pick_any;
   assign o_req_ready = in_idle ? pick : '0;

   always_comb begin
      state_d      = state_q;
      start_cnt_d  = start_cnt_q;
      gap_cnt_d    = gap_cnt_q;
      ptr_d        = ptr_q;
      lock_d       = lock_q;
      lock_owner_d = lock_owner_q;
      lock_cnt_d   = lock_cnt_q;
      tag_d        = tag_q;
      cmd_d        = 1'b0;
      cmd_data_d   = cmd_data_q;
      window_d     = (state_q == ST_ISSUE);
      reply_data_d = (i_reply && window_q) ? i_reply_data : reply_data_q;
      orphan_d     = i_reply && !window_q;

      unique case (state_q)
         ST_STARTUP: begin
            if (start_cnt_q == SCW'(STARTUP_CYCLES - 1)) state_d = ST_IDLE;
            else start_cnt_d = start_cnt_q + SCW'(1);
         end
         ST_IDLE: begin
            if (xfer) begin
               state_d    = ST_ISSUE;
               ptr_d      = win_idx;
               tag_d      = win_idx;
               cmd_d      = 1'b1;
               cmd_data_d = req_word[win_idx];
               if (i_req_lock[win_idx]) begin
                  lock_d       = 1'b1;
                  lock_owner_d = win_idx;
                  lock_cnt_d   = LCW'(LOCK_TIMEOUT);
               end else begin
                  lock_d = 1'b0;
               end
            end else if (lock_q) begin
               if (lock_cnt_q == '0) lock_d = 1'b0;
               else lock_cnt_d = lock_cnt_q - LCW'(1);
            end
         end
         ST_ISSUE: begin
            // The arbitration cycle in IDLE is itself the last idle cycle of the gap.
            if (GAP_CYCLES > 1) begin
               state_d   = ST_GAP;
               gap_cnt_d = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_GAP: begin
            if (gap_cnt_q == GCW'(GAP_CYCLES - 2)) state_d = ST_IDLE;
            else gap_cnt_d = gap_cnt_q + GCW'(1);
         end
         default: state_d = ST_STARTUP;
      endcase
   end

   always_ff @(posedge i_command_clk) begin
      if (i_reset) begin
         state_q       <= ST_STARTUP;
         start_cnt_q   <= '0;
         gap_cnt_q     <= '0;
         ptr_q         <= PW'(N_REQ - 1);
         lock_q        <= 1'b0;
         lock_owner_q  <= '0;
         lock_cnt_q    <= '0;
         tag_q         <= '0;
         window_q      <= 1'b0;
         cmd_q         <= 1'b0;
         cmd_data_q    <= '0;
         reply_valid_q <= '0;
         reply_data_q  <= '0;
         orphan_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         start_cnt_q   <= start_cnt_d;
         gap_cnt_q     <= gap_cnt_d;
         ptr_q         <= ptr_d;
         lock_q        <= lock_d;
         lock_owner_q  <= lock_owner_d;
         lock_cnt_q    <= lock_cnt_d;
         tag_q         <= tag_d;
         window_q      <= window_d;
         cmd_q         <= cmd_d;
         cmd_data_q    <= cmd_data_d;
         reply_valid_q <= reply_valid_d;
         reply_data_q  <= reply_data_d;
         orphan_q      <= orphan_d;
      end
   end

   assign o_command      = cmd_q;
   assign o_command_data = cmd_data_q;
   assign o_reply_valid  = reply_valid_q;
   assign o_reply_data   = reply_data_q;
   assign o_orphan       = orphan_q;
   assign o_busy         = (state_q == ST_STARTUP);

endmodule
